// File: rtl/cobra_ctrl_pkg.sv
// Shared types and constants for the cyber_cobra run controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cobra_ctrl_pkg;

    // Controller states; encoding kept fixed so waveforms stay comparable across revisions.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } run_state_t;

    // Default core PC width (byte address).
    localparam int DEF_PC_W = 8;

    // Instruction memory depth in words for the default PC width.
    localparam int IMEM_WORDS = 2 ** (DEF_PC_W - 2);

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

    // Instruction memory depth in words for an arbitrary PC width.
    function automatic int imem_words(input int pc_w);
        return 2 ** (pc_w - 2);
    endfunction

endpackage

// File: rtl/cobra_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
// Latency: count updates one edge after enable; o_cnt_inc is combinational.
// Backpressure: none; holds at all-ones instead of wrapping.
module cobra_cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_inc
);

    logic [W-1:0] r_cnt;

    // Raw (wrapping) successor; callers use it to look one cycle ahead.
    assign o_cnt_inc = r_cnt + W'(1);
    assign o_cnt     = r_cnt;

    // Clear wins over enable; stop advancing once all-ones is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= o_cnt_inc;
        end
    end

endmodule

// File: rtl/cobra_run_ctrl.sv
// Loads a program into cyber_cobra imem, runs the core and stops it on halt, budget or abort.
// Latency: imem write one cycle after each accepted beat; stop visible the cycle after the condition.
// Backpressure: load_ready low outside IDLE/LOAD/DONE and once the write pointer reaches the top of imem.
module cobra_run_ctrl
    import cobra_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             imem_we,
    output logic [PC_W-1:0]  imem_waddr,
    output logic [WIDTH-1:0] imem_wdata,
    output logic             core_rst,
    input  logic [PC_W-1:0]  core_pc,
    input  logic [PC_W-1:0]  core_next_pc,
    input  logic [WIDTH-1:0] core_out,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles
);

    localparam int WORDS = imem_words(PC_W);
    // Word counter is one bit wider than a word index so "full" is representable.
    localparam int CW    = PC_W - 1;

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    logic [CW-1:0]    r_wcnt;
    logic [CW-1:0]    w_wcnt_nxt;
    logic [PC_W-3:0]  w_word;
    logic             w_restart;
    logic             w_load_st;
    logic             w_full;
    logic             w_fill;
    logic             w_beat;
    logic             w_hit_halt;
    logic             w_hit_to;
    logic             w_stop;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             r_imem_we;
    logic [PC_W-1:0]  r_imem_waddr;
    logic [WIDTH-1:0] r_imem_wdata;
    logic             r_halted;
    logic             r_timeout;
    logic [WIDTH-1:0] r_result;

    // A fresh load always starts at word 0 when coming from IDLE or DONE.
    assign w_restart  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_load_st  = w_restart || (r_state == ST_LOAD);
    assign w_full     = (r_wcnt == CW'(WORDS));
    assign load_ready = w_load_st && !w_full;
    assign w_beat     = load_valid && load_ready;

    assign w_word     = w_restart ? '0 : r_wcnt[PC_W-3:0];
    assign w_wcnt_nxt = {1'b0, w_word} + CW'(1);
    // This beat writes the last imem word; the pointer must not wrap past it.
    assign w_fill     = (w_wcnt_nxt == CW'(WORDS));

    // Stop sources; abort outranks halt, halt outranks the budget.
    assign w_hit_halt = (core_next_pc == core_pc);
    assign w_hit_to   = (cycle_limit != '0) && (w_cnt_inc == cycle_limit);
    assign w_stop     = (r_state == ST_RUN) && (abort || w_hit_halt || w_hit_to);

    assign w_cnt_clr  = (r_state == ST_ARM);
    assign w_cnt_en   = (r_state == ST_RUN);

    // Core sits in reset everywhere but RUN, including straight out of async reset.
    assign core_rst   = (r_state != ST_RUN);
    assign busy       = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign halted     = r_halted;
    assign timeout    = r_timeout;
    assign result     = r_result;
    assign cycles     = w_cnt;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;

    cobra_cycle_counter #(
        .W (CNT_W)
    ) u_cycle_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_cnt     (w_cnt),
        .o_cnt_inc (w_cnt_inc)
    );

    // Next-state decode; a load beat beats a coincident start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_beat) begin
                    w_state_nxt = (load_last || w_fill) ? ST_IDLE : ST_LOAD;
                end else if (start) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_LOAD: begin
                if (w_beat && (load_last || w_fill)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write pointer; a run releases it so a full memory does not lock out the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (w_beat) begin
            r_wcnt <= w_wcnt_nxt;
        end else if (r_state == ST_ARM) begin
            r_wcnt <= '0;
        end
    end

    // Registered imem write port: strobe for one cycle per beat, address/data held between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= w_beat;
            if (w_beat) begin
                r_imem_waddr <= PC_W'(w_word) * PC_W'(PC_STEP);
                r_imem_wdata <= load_data;
            end
        end
    end

    // Run outcome: cleared on ARM, captured on the stopping cycle, held through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
        end else if (r_state == ST_ARM) begin
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
        end else if (w_stop) begin
            r_halted  <= !abort && w_hit_halt;
            r_timeout <= !abort && !w_hit_halt && w_hit_to;
            r_result  <= core_out;
        end
    end

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Scoreboard bench for cobra_run_ctrl with a small behavioural core model.
// Latency: checks imem writes land exactly one cycle after their beat.
// Backpressure: exercises load_ready drop when imem fills.
module tb_cobra_run_ctrl;

    localparam int WIDTH = 32;
    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_last = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cycle_limit = '0;
    logic             imem_we;
    logic [PC_W-1:0]  imem_waddr;
    logic [WIDTH-1:0] imem_wdata;
    logic             core_rst;
    logic [PC_W-1:0]  core_pc;
    logic [PC_W-1:0]  core_next_pc;
    logic [WIDTH-1:0] core_out;
    logic             busy;
    logic             done;
    logic             halted;
    logic             timeout;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cycles;

    always #5 clk = ~clk;

    cobra_run_ctrl #(.WIDTH(WIDTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .start        (start),
        .abort        (abort),
        .cycle_limit  (cycle_limit),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .core_pc      (core_pc),
        .core_next_pc (core_next_pc),
        .core_out     (core_out),
        .busy         (busy),
        .done         (done),
        .halted       (halted),
        .timeout      (timeout),
        .result       (result),
        .cycles       (cycles)
    );

    // Core model: straight-line PC stepping by 4, optional self-loop at PC=12 where OUT=0x55.
    logic [PC_W-1:0] m_pc;
    logic            loop_en = 1'b0;
    always @(posedge clk or posedge core_rst) begin
        if (core_rst) m_pc <= '0;
        else          m_pc <= core_next_pc;
    end
    assign core_pc      = m_pc;
    assign core_next_pc = (loop_en && m_pc == 8'd12) ? m_pc : m_pc + 8'd4;
    assign core_out     = (m_pc == 8'd12) ? 32'h55 : {24'd0, m_pc};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [PC_W-1:0]  a;
        logic [WIDTH-1:0] d;
        int               c;
    } wr_t;

    typedef struct {
        logic             h;
        logic             t;
        logic [CNT_W-1:0] n;
        logic [WIDTH-1:0] r;
    } run_t;

    wr_t  wr_q[$];
    run_t run_q[$];
    wr_t  wr_e;
    run_t run_e;
    logic prev_done = 1'b0;

    // imem write monitor.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                wr_e = wr_q.pop_front();
                chk("wr_addr", 64'(imem_waddr), 64'(wr_e.a));
                chk("wr_data", 64'(imem_wdata), 64'(wr_e.d));
                chk("wr_cycle", 64'(cyc), 64'(wr_e.c));
            end
        end
    end

    // Run completion monitor: fires on the first DONE cycle.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            chk("run_expected", 64'(run_q.size() != 0), 64'd1);
            if (run_q.size() != 0) begin
                run_e = run_q.pop_front();
                chk("run_halted", 64'(halted), 64'(run_e.h));
                chk("run_timeout", 64'(timeout), 64'(run_e.t));
                chk("run_cycles", 64'(cycles), 64'(run_e.n));
                chk("run_result", 64'(result), 64'(run_e.r));
                chk("run_core_rst", 64'(core_rst), 64'd1);
                chk("run_busy", 64'(busy), 64'd0);
            end
        end
        prev_done = done;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_waddr"}, 64'(imem_waddr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_cycles"}, 64'(cycles), 64'd0);
        chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
    endtask

    // One load beat, driven at a negedge; returns at the next negedge.
    task automatic beat(input logic [WIDTH-1:0] d, input logic last, input logic [PC_W-1:0] exp_addr);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready_wait", 64'(n < 50), 64'd1);
        wr_q.push_back('{exp_addr, d, cyc + 1});
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_start(input logic push, input logic h, input logic t,
                             input logic [CNT_W-1:0] n, input logic [WIDTH-1:0] r);
        start = 1'b1;
        if (push) run_q.push_back('{h, t, n, r});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_wait"}, 64'(n < 200), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-word program.
        beat(32'hA000_0000, 1'b0, 8'd0);
        beat(32'hA000_0001, 1'b0, 8'd4);
        beat(32'hA000_0002, 1'b1, 8'd8);
        @(negedge clk);
        chk("load3_ready", 64'(load_ready), 64'd1);
        chk("load3_we_low", 64'(imem_we), 64'd0);
        chk("load3_not_busy", 64'(busy), 64'd0);

        // Halt on self-loop at PC=12 in run cycle 4.
        loop_en = 1'b1;
        run_start(1'b1, 1'b1, 1'b0, 16'd4, 32'h55);
        chk("arm_busy", 64'(busy), 64'd1);
        chk("arm_core_rst", 64'(core_rst), 64'd1);
        chk("arm_load_ready", 64'(load_ready), 64'd0);
        @(negedge clk);
        chk("run1_core_rst", 64'(core_rst), 64'd0);
        wait_done("halt");

        // Budget timeout after exactly 10 cycles, never-halting program.
        loop_en = 1'b0;
        cycle_limit = 16'd10;
        run_start(1'b1, 1'b0, 1'b1, 16'd10, 32'd36);
        wait_done("limit");
        cycle_limit = '0;

        // Abort coinciding with the self-loop.
        loop_en = 1'b1;
        run_start(1'b1, 1'b0, 1'b0, 16'd4, 32'h55);
        n = 0;
        while (core_pc != 8'd12 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pc_wait", 64'(n < 50), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 64'(done), 64'd1);

        // start and a beat together in DONE: load wins.
        start = 1'b1;
        beat(32'hD000_0000, 1'b0, 8'd0);
        start = 1'b0;
        chk("coinc_not_busy", 64'(busy), 64'd0);
        chk("coinc_left_done", 64'(done), 64'd0);
        chk("coinc_in_load", 64'(load_ready), 64'd1);
        beat(32'hD000_0001, 1'b1, 8'd4);
        repeat (3) @(negedge clk);
        chk("coinc_no_run", 64'(core_rst), 64'd1);

        // Fill the whole memory without load_last.
        for (int i = 0; i < 64; i++) begin
            beat(32'hF000_0000 + 32'(i), 1'b0, 8'(i * 4));
        end
        chk("fill_ready_low", 64'(load_ready), 64'd0);
        chk("fill_not_busy", 64'(busy), 64'd0);
        chk("fill_not_done", 64'(done), 64'd0);
        @(negedge clk);

        // Async reset in run cycle 5, then a clean rerun.
        loop_en = 1'b0;
        run_start(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        chk("mid_run_cycles", 64'(cycles), 64'd4);
        chk("mid_run_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        loop_en = 1'b1;
        run_start(1'b1, 1'b1, 1'b0, 16'd4, 32'h55);
        wait_done("rerun");

        repeat (2) @(negedge clk);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("run_q_drained", 64'(run_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
